mm_wr_arb: RTL and testbench
============================

Name: mm_wr_arb

Overview:
- Round-robin arbiter sharing the single synchronous write port of the 16x8 register memory (mm) among NREQ requesters.
- Supports locked bursts of up to MAX_BURST beats.
- Drives mm's waddr/wdata/we from a registered output stage; mm's async read ports are untouched.
- Sits between producers (e.g. ALU writeback, loader, debug port) and mm.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 4, address width (matches mm depth 16)
DW, 8, data width (matches mm)
MAX_BURST, 4, max beats per grant before forced release (1..16)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester beat valid
req_addr  in  NREQ*AW  packed addresses, requester i at bits [i*AW +: AW]
req_data  in  NREQ*DW  packed data, requester i at bits [i*DW +: DW]
req_last  in  NREQ  beat is final of burst (single writes assert it)
req_ready  out  NREQ  combinational accept, one-hot or zero
mm_waddr  out  AW  registered to mm.waddr
mm_wdata  out  DW  registered to mm.wdata
mm_we  out  1  registered to mm.we
grant_id  out  clog2(NREQ)  current/last owner index, registered
busy  out  1  high in BURST state, registered

Behaviour:
- Reset: on posedge with rst=1, the following are forced:
  - state=IDLE, rr_ptr=0, beat_cnt=0
  - mm_we=0, mm_waddr=0, mm_wdata=0, grant_id=0, busy=0
  - req_ready=0 in the reset cycle.
- Beat accept: a beat transfers when req_valid[i] && req_ready[i] in cycle N.
  - At posedge ending N: mm_waddr/mm_wdata load that beat, mm_we=1.
  - mm writes at the posedge ending N+1. Acceptance-to-memory latency is 2 edges.
  - mm_we=0 in any cycle following a non-accept cycle.
- Throughput: one beat per cycle max; back-to-back beats (same or different requesters) produce continuous mm_we=1.
- IDLE state:
  - Winner is the first i with req_valid[i] set, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[winner]=1 combinationally; grant_id<=winner.
  - If req_last[winner]=1 (or MAX_BURST=1): stay IDLE, rr_ptr<=winner+1 mod NREQ.
  - Otherwise: go to BURST, owner latched, beat_cnt<=1, busy<=1.
  - No valid requests: no accept, rr_ptr unchanged.
- BURST state:
  - Only req_ready[owner] may assert, and only when req_valid[owner]=1. Other requesters wait.
  - Owner valid low: bubble (mm_we=0 next cycle); lock held, beat_cnt unchanged.
  - Accepted beat with req_last=1, or beat_cnt+1==MAX_BURST: go to IDLE, busy<=0, rr_ptr<=owner+1 mod NREQ, beat_cnt<=0.
  - Forced release does not consume req_last; the owner's following beats re-arbitrate as a new burst.
  - Otherwise beat_cnt increments.
- Pointer wrap: owner NREQ-1 sets rr_ptr to 0.
- Fairness: after a release, the just-served requester has lowest priority; any continuously requesting requester is granted within NREQ-1 grants.
- Simultaneous events:
  - req_last and the MAX_BURST limit on the same beat produce a single release.
  - rst overrides any accept in the same cycle.
- Reset mid-burst: the burst is aborted. A beat captured in the output register before reset is suppressed (mm_we=0 after the reset edge) and is not written.
- Address collisions between requesters are not detected. Write order equals grant order. mm's write-first read behaviour is the consumer's concern.
- req_ready depends only on state, rr_ptr, owner and req_valid (no path from req_addr/req_data/req_last to req_ready except req_last's effect on next state).

Test Plan:
- Reset, then req0 single write: req0 writes addr 3, data A5, last=1 → req_ready[0]=1 same cycle. mm_we=1, mm_waddr=3, mm_wdata=A5 the next cycle. mm read of addr 3 returns A5 after the following posedge. rr_ptr=1.
- Round robin: all 4 requesters continuously valid with single writes (addr=i, data=10+i), starting rr_ptr=0 → grant order 0,1,2,3,0. mm_we stays high 5 consecutive cycles. mm[0..3]=10,11,12,13.
- Burst lock: req1 sends 3 beats (addr 8,9,A; data 01,02,03; last on 3rd) while req2 is valid → req_ready[2]=0 throughout. busy=1 for beats 1-2. req2 is granted in the cycle after release.
- Forced release, MAX_BURST=4: req0 sends 6 beats with no last while req3 is valid → after 4 beats, state IDLE. req3 is granted next. req0's remaining 2 beats follow as a new burst.
- Owner stall: req2 in BURST drops valid for 2 cycles while req0 is valid → 2 cycles of mm_we=0, req_ready[0]=0, lock retained. Burst completes on req2's last.
- Reset mid-burst: rst=1 during beat 2 of a req1 burst → mm_we=0 after the edge. busy=0, grant_id=0, rr_ptr=0. That beat's address is unchanged in mm. The next request is arbitrated from requester 0.

Source files
------------

// File: rtl/mm_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mm_wr_arb
//  Description : Round-robin arbiter that shares the single synchronous write
//                port of the 16x8 register memory (mm) among NREQ producers.
//                A requester that starts a multi-beat burst keeps the port
//                until it signals req_last or MAX_BURST beats have been
//                accepted. Accepted beats are captured in a registered output
//                stage that drives mm's waddr/wdata/we.
//
//  Ports
//    clk           : clock, all state updates on the rising edge
//    rst           : synchronous active-high reset
//    req_valid_i   : per-requester beat valid
//    req_addr_i    : packed addresses, requester i at [i*AW +: AW]
//    req_data_i    : packed data, requester i at [i*DW +: DW]
//    req_last_i    : per-requester final-beat flag
//    req_ready_o   : combinational accept, one-hot or zero
//    mm_waddr_o    : registered write address to mm
//    mm_wdata_o    : registered write data to mm
//    mm_we_o       : registered write enable to mm
//    grant_id_o    : index of the current / most recent owner
//    busy_o        : high while a burst holds the lock
//
//  Revision    : 1.0  initial release
// ============================================================================
module mm_wr_arb #(
    parameter int NREQ      = 4,
    parameter int AW        = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [NREQ*AW-1:0]       req_addr_i,
    input  logic [NREQ*DW-1:0]       req_data_i,
    input  logic [NREQ-1:0]          req_last_i,
    output logic [NREQ-1:0]          req_ready_o,
    output logic [AW-1:0]            mm_waddr_o,
    output logic [DW-1:0]            mm_wdata_o,
    output logic                     mm_we_o,
    output logic [$clog2(NREQ)-1:0]  grant_id_o,
    output logic                     busy_o
);

    localparam int IDW = $clog2(NREQ);
    localparam int BCW = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]     state_q,    state_d;
    logic [IDW-1:0] rr_ptr_q,   rr_ptr_d;
    logic [IDW-1:0] owner_q,    owner_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
    logic           busy_q,     busy_d;
    logic           mm_we_q,    mm_we_d;
    logic [AW-1:0]  mm_waddr_q, mm_waddr_d;
    logic [DW-1:0]  mm_wdata_q, mm_wdata_d;

    // Next pointer after serving requester p, wrapping NREQ-1 to 0.
    function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] p);
        if (p == IDW'(NREQ - 1)) begin
            return '0;
        end
        return p + IDW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Round-robin winner search.
    // The valid vector is rotated so that bit 0 is the requester at
    // rr_ptr; the first set bit gives the offset of the winner.
    // ------------------------------------------------------------------
    logic [2*NREQ-1:0] valid_dbl;
    logic [NREQ-1:0]   valid_rot;
    logic [IDW-1:0]    win_off;
    logic              win_found;
    logic [IDW:0]      win_sum;
    logic [IDW-1:0]    win_idx;

    always_comb begin
        valid_dbl = {req_valid_i, req_valid_i};
        valid_rot = NREQ'(valid_dbl >> rr_ptr_q);
        win_off   = '0;
        win_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && valid_rot[k]) begin
                win_found = 1'b1;
                win_off   = IDW'(k);
            end
        end
        win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
        if (win_sum >= (IDW+1)'(NREQ)) begin
            win_sum = win_sum - (IDW+1)'(NREQ);
        end
        win_idx = win_sum[IDW-1:0];
    end

    // ------------------------------------------------------------------
    // Accept decision. Depends only on state, pointer, owner and valid;
    // forced low while rst is asserted so no beat is taken in the reset
    // cycle.
    // ------------------------------------------------------------------
    logic [NREQ-1:0] ready_w;
    logic [IDW-1:0]  acc_id;
    logic            accept;

    always_comb begin
        ready_w = '0;
        acc_id  = '0;
        if (!rst) begin
            if (state_q == ST_IDLE) begin
                acc_id = win_idx;
                if (win_found) begin
                    ready_w = NREQ'(1) << win_idx;
                end
            end else begin
                acc_id = owner_q;
                if (req_valid_i[owner_q]) begin
                    ready_w = NREQ'(1) << owner_q;
                end
            end
        end
        accept = |ready_w;
    end

    assign req_ready_o = ready_w;

    // Payload of the accepted beat.
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_data;
    logic          acc_last;

    always_comb begin
        acc_addr = req_addr_i[acc_id*AW +: AW];
        acc_data = req_data_i[acc_id*DW +: DW];
        acc_last = req_last_i[acc_id];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        busy_d     = busy_q;

        // Output stage: capture every accepted beat, hold address/data
        // otherwise so mm sees stable inputs while we is low.
        mm_we_d    = accept;
        mm_waddr_d = accept ? acc_addr : mm_waddr_q;
        mm_wdata_d = accept ? acc_data : mm_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    grant_id_d = acc_id;
                    if (acc_last || (MAX_BURST == 1)) begin
                        rr_ptr_d = ptr_inc(acc_id);
                    end else begin
                        state_d    = ST_BURST;
                        owner_d    = acc_id;
                        beat_cnt_d = BCW'(1);
                        busy_d     = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (accept) begin
                    // req_last and the beat limit landing together yield
                    // one release; a limit release leaves the owner's
                    // remaining beats to be arbitrated as a new burst.
                    if (acc_last || (beat_cnt_q == BCW'(MAX_BURST - 1))) begin
                        state_d    = ST_IDLE;
                        busy_d     = 1'b0;
                        rr_ptr_d   = ptr_inc(owner_q);
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BCW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
            mm_we_q    <= 1'b0;
            mm_waddr_q <= '0;
            mm_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
            busy_q     <= busy_d;
            mm_we_q    <= mm_we_d;
            mm_waddr_q <= mm_waddr_d;
            mm_wdata_q <= mm_wdata_d;
        end
    end

    // A beat already sitting in the output register when reset arrives
    // must not reach mm, so the enable is masked by rst.
    assign mm_we_o    = mm_we_q & ~rst;
    assign mm_waddr_o = mm_waddr_q;
    assign mm_wdata_o = mm_wdata_q;
    assign grant_id_o = grant_id_q;
    assign busy_o     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mm_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mm_wr_arb
//  Description : Self-checking bench for mm_wr_arb (NREQ=4, AW=4, DW=8,
//                MAX_BURST=4). Includes a behavioural model of mm and of the
//                arbitration rules, a vector table, directed corner-case
//                sequences and a randomized run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mm_wr_arb;

    localparam int NREQ = 4;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  mm_waddr;
    logic [7:0]  mm_wdata;
    logic        mm_we;
    logic [1:0]  grant_id;
    logic        busy;

    always #5 clk = ~clk;

    mm_wr_arb #(.NREQ(4), .AW(4), .DW(8), .MAX_BURST(MAXB)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .mm_waddr_o  (mm_waddr),
        .mm_wdata_o  (mm_wdata),
        .mm_we_o     (mm_we),
        .grant_id_o  (grant_id),
        .busy_o      (busy)
    );

    // Memory fed by the DUT
    logic [7:0] tb_mem [16];
    always @(posedge clk) begin
        if (mm_we) tb_mem[mm_waddr] <= mm_wdata;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: lock owner (-1 = none), beats taken, pointer
    // ------------------------------------------------------------------
    bit         m_init = 0;
    int         m_ptr, m_owner, m_beats, m_gid;
    logic       m_we, m_busy;
    logic [3:0] m_addr;
    logic [7:0] m_data;
    logic [7:0] ref_mem [16];

    function automatic int m_grantee(input logic r, input logic [3:0] v);
        if (r) return -1;
        if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic m_step(input logic r, input logic [3:0] l, input logic [15:0] a,
                          input logic [31:0] d, input int g);
        if (r) begin
            m_init = 1; m_ptr = 0; m_owner = -1; m_beats = 0; m_gid = 0;
            m_we = 0; m_busy = 0; m_addr = 0; m_data = 0;
            return;
        end
        if (!m_init) return;
        if (m_we) ref_mem[m_addr] = m_data;
        m_we = (g >= 0);
        if (g >= 0) begin
            m_addr = a[g*4 +: 4];
            m_data = d[g*8 +: 8];
            m_gid  = g;
            if (m_owner < 0) begin
                if (l[g]) m_ptr = (g + 1) % NREQ;
                else begin m_owner = g; m_beats = 1; end
            end else begin
                m_beats++;
                if (l[g] || m_beats == MAXB) begin
                    m_owner = -1; m_ptr = (g + 1) % NREQ; m_beats = 0;
                end
            end
        end
        m_busy = (m_owner >= 0);
    endtask

    // Observed values of the most recent cycle
    logic [3:0] obs_rdy;
    logic       obs_we, obs_busy;
    logic [3:0] obs_addr;
    logic [7:0] obs_data;
    logic [1:0] obs_gid;

    // One clock cycle: drive, sample mid-cycle, compare with model, advance.
    task automatic cycle(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic [15:0] a, input logic [31:0] d);
        int g;
        rst = r; req_valid = v; req_last = l; req_addr = a; req_data = d;
        g = m_grantee(r, v);
        @(negedge clk);
        obs_rdy = req_ready; obs_we = mm_we; obs_addr = mm_waddr;
        obs_data = mm_wdata; obs_gid = grant_id; obs_busy = busy;
        if (m_init) begin
            chk("m_ready", obs_rdy, (g >= 0) ? (32'd1 << g) : 32'd0);
            chk("m_we",    obs_we, m_we && !r);
            chk("m_waddr", obs_addr, m_addr);
            chk("m_wdata", obs_data, m_data);
            chk("m_gid",   obs_gid, m_gid);
            chk("m_busy",  obs_busy, m_busy);
        end
        @(posedge clk);
        m_step(r, l, a, d, g);
        #1;
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  v;
        logic [3:0]  l;
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  e_rdy;
        logic        e_we;
        logic [3:0]  e_addr;
        logic [7:0]  e_data;
        logic [1:0]  e_gid;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mkv(logic r, logic [3:0] v, logic [3:0] l, logic [15:0] a,
                                 logic [31:0] d, logic [3:0] er, logic ew, logic [3:0] ea,
                                 logic [7:0] ed, logic [1:0] eg, logic eb);
        vec_t t;
        t.r = r; t.v = v; t.l = l; t.a = a; t.d = d;
        t.e_rdy = er; t.e_we = ew; t.e_addr = ea; t.e_data = ed; t.e_gid = eg; t.e_busy = eb;
        return t;
    endfunction

    vec_t tab [17];
    logic [7:0] keep6, keep7;

    initial begin
        for (int i = 0; i < 16; i++) begin
            tb_mem[i]  = 8'h00;
            ref_mem[i] = 8'h00;
        end

        // single write, round robin, burst lock
        tab[0]  = mkv(1, 4'h1, 4'h1, 16'h0003, 32'h000000A5, 4'h0, 0, 4'h0, 8'h00, 0, 0);
        tab[1]  = mkv(0, 4'h1, 4'h1, 16'h0003, 32'h000000A5, 4'h1, 0, 4'h0, 8'h00, 0, 0);
        tab[2]  = mkv(0, 4'h0, 4'h0, 16'h0000, 32'h00000000, 4'h0, 1, 4'h3, 8'hA5, 0, 0);
        tab[3]  = mkv(0, 4'h0, 4'h0, 16'h0000, 32'h00000000, 4'h0, 0, 4'h3, 8'hA5, 0, 0);
        tab[4]  = mkv(1, 4'h0, 4'h0, 16'h0000, 32'h00000000, 4'h0, 0, 4'h3, 8'hA5, 0, 0);
        tab[5]  = mkv(0, 4'hF, 4'hF, 16'h3210, 32'h13121110, 4'h1, 0, 4'h0, 8'h00, 0, 0);
        tab[6]  = mkv(0, 4'hF, 4'hF, 16'h3210, 32'h13121110, 4'h2, 1, 4'h0, 8'h10, 0, 0);
        tab[7]  = mkv(0, 4'hF, 4'hF, 16'h3210, 32'h13121110, 4'h4, 1, 4'h1, 8'h11, 1, 0);
        tab[8]  = mkv(0, 4'hF, 4'hF, 16'h3210, 32'h13121110, 4'h8, 1, 4'h2, 8'h12, 2, 0);
        tab[9]  = mkv(0, 4'hF, 4'hF, 16'h3210, 32'h13121110, 4'h1, 1, 4'h3, 8'h13, 3, 0);
        tab[10] = mkv(0, 4'h0, 4'h0, 16'h0000, 32'h00000000, 4'h0, 1, 4'h0, 8'h10, 0, 0);
        tab[11] = mkv(0, 4'h0, 4'h0, 16'h0000, 32'h00000000, 4'h0, 0, 4'h0, 8'h10, 0, 0);
        tab[12] = mkv(0, 4'h6, 4'h4, 16'h0F80, 32'h00EE0100, 4'h2, 0, 4'h0, 8'h10, 0, 0);
        tab[13] = mkv(0, 4'h6, 4'h4, 16'h0F90, 32'h00EE0200, 4'h2, 1, 4'h8, 8'h01, 1, 1);
        tab[14] = mkv(0, 4'h6, 4'h6, 16'h0FA0, 32'h00EE0300, 4'h2, 1, 4'h9, 8'h02, 1, 1);
        tab[15] = mkv(0, 4'h4, 4'h4, 16'h0F00, 32'h00EE0000, 4'h4, 1, 4'hA, 8'h03, 1, 0);
        tab[16] = mkv(0, 4'h0, 4'h0, 16'h0000, 32'h00000000, 4'h0, 1, 4'hF, 8'hEE, 2, 0);

        cycle(1, 4'h0, 4'h0, 16'h0, 32'h0);

        for (int i = 0; i < 17; i++) begin
            cycle(tab[i].r, tab[i].v, tab[i].l, tab[i].a, tab[i].d);
            chk($sformatf("t%0d_ready", i), obs_rdy,  tab[i].e_rdy);
            chk($sformatf("t%0d_we", i),    obs_we,   tab[i].e_we);
            chk($sformatf("t%0d_waddr", i), obs_addr, tab[i].e_addr);
            chk($sformatf("t%0d_wdata", i), obs_data, tab[i].e_data);
            chk($sformatf("t%0d_gid", i),   obs_gid,  tab[i].e_gid);
            chk($sformatf("t%0d_busy", i),  obs_busy, tab[i].e_busy);
        end
        cycle(0, 4'h0, 4'h0, 16'h0, 32'h0);
        chk("mem0", tb_mem[0], 8'h10);
        chk("mem1", tb_mem[1], 8'h11);
        chk("mem2", tb_mem[2], 8'h12);
        chk("mem3", tb_mem[3], 8'h13);
        chk("mem8", tb_mem[8], 8'h01);
        chk("mem9", tb_mem[9], 8'h02);
        chk("memA", tb_mem[10], 8'h03);
        chk("memF", tb_mem[15], 8'hEE);

        // Forced release after MAX_BURST beats; req3 waiting
        cycle(1, 4'h0, 4'h0, 16'h0, 32'h0);
        for (int k = 0; k < 7; k++) begin
            logic [3:0] v;
            v = (k <= 4) ? 4'h9 : 4'h1;
            cycle(0, v, 4'h8, {4'hC, 8'h00, 4'(k)}, {8'h33, 16'h0000, 8'(8'h20 + k)});
            if (k == 3) chk("fr_last_beat_ready", obs_rdy, 4'h1);
            if (k == 4) begin
                chk("fr_req3_ready", obs_rdy, 4'h8);
                chk("fr_busy_released", obs_busy, 1'b0);
            end
            if (k == 5) chk("fr_req0_regrant", obs_rdy, 4'h1);
            if (k == 6) chk("fr_new_burst_busy", obs_busy, 1'b1);
        end

        // Owner stall inside a burst
        cycle(1, 4'h0, 4'h0, 16'h0, 32'h0);
        cycle(0, 4'h4, 4'h0, 16'h0500, 32'h00550000);
        chk("st_grant2", obs_rdy, 4'h4);
        cycle(0, 4'h1, 4'h0, 16'h0001, 32'h00000011);
        chk("st_ready_s1", obs_rdy, 4'h0);
        cycle(0, 4'h1, 4'h0, 16'h0001, 32'h00000011);
        chk("st_ready_s2", obs_rdy, 4'h0);
        chk("st_we_s2", obs_we, 1'b0);
        chk("st_busy_s2", obs_busy, 1'b1);
        cycle(0, 4'h5, 4'h5, 16'h0601, 32'h00560011);
        chk("st_last_ready", obs_rdy, 4'h4);
        chk("st_we_s3", obs_we, 1'b0);
        cycle(0, 4'h1, 4'h1, 16'h0001, 32'h00000011);
        chk("st_after_ready", obs_rdy, 4'h1);
        chk("st_after_busy", obs_busy, 1'b0);

        // Reset in the middle of a req1 burst
        cycle(1, 4'h0, 4'h0, 16'h0, 32'h0);
        keep6 = tb_mem[6];
        keep7 = tb_mem[7];
        cycle(0, 4'h2, 4'h0, 16'h0060, 32'h00006600);
        chk("rb_grant1", obs_rdy, 4'h2);
        cycle(1, 4'h2, 4'h0, 16'h0070, 32'h00007700);
        chk("rb_ready_in_rst", obs_rdy, 4'h0);
        chk("rb_we_in_rst", obs_we, 1'b0);
        cycle(0, 4'h3, 4'h3, 16'h00DE, 32'h000077AA);
        chk("rb_we_after", obs_we, 1'b0);
        chk("rb_busy_after", obs_busy, 1'b0);
        chk("rb_gid_after", obs_gid, 2'd0);
        chk("rb_ready_from0", obs_rdy, 4'h1);
        cycle(0, 4'h0, 4'h0, 16'h0, 32'h0);
        chk("rb_mem6", tb_mem[6], keep6);
        chk("rb_mem7", tb_mem[7], keep7);

        // Randomized run against the model
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 63) == 0, 4'($urandom), 4'($urandom & $urandom),
                  16'($urandom), 32'($urandom));
        end
        cycle(0, 4'h0, 4'h0, 16'h0, 32'h0);
        cycle(0, 4'h0, 4'h0, 16'h0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("final_mem%0d", i), tb_mem[i], ref_mem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
